// File: rtl/memacc_pkg.sv
// rtl/memacc_pkg.sv - shared width codes, FSM state type and lane-mask helpers for memacc_hs
package memacc_pkg;

  // RISC-V load/store funct3 width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  // Byte-enable mask for an access of the given width at byte offset off.
  // Computed for an 8-lane bus; narrower buses keep the low lanes, so a
  // misaligned access simply loses the lanes shifted past the top.
  function automatic logic [7:0] be_gen(input logic [2:0] width, input logic [2:0] off);
    logic [7:0] be;
    case (width[1:0])
      2'b00:   be = 8'h01 << off;
      2'b01:   be = 8'h03 << off;
      2'b10:   be = 8'h0F << off;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

  // True when the byte offset is not a multiple of the access size
  function automatic logic is_misaligned(input logic [2:0] width, input logic [2:0] off);
    logic mis;
    case (width[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memacc_hs_if.sv
// rtl/memacc_hs_if.sv - data-memory req/ack bus between memacc_hs and the memory
interface memacc_hs_if #(
  parameter int XLEN = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN/8-1:0] dmem_be;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN-1:0]   dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/load_aligner.sv
// rtl/load_aligner.sv - shifts a read word down to its byte offset and sign/zero extends it
module load_aligner
  import memacc_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] offset,
  input  logic [2:0]       width,
  output logic [XLEN-1:0]  result
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  // Extend the addressed field; D (and W on a 32-bit bus) is the shifted word itself
  always_comb begin
    result = shifted;
    case (width)
      F3_B:    result = XLEN'($signed(shifted[7:0]));
      F3_H:    result = XLEN'($signed(shifted[15:0]));
      F3_W:    result = XLEN'($signed(shifted[31:0]));
      F3_BU:   result = XLEN'(shifted[7:0]);
      F3_HU:   result = XLEN'(shifted[15:0]);
      F3_WU:   result = XLEN'(shifted[31:0]);
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/memacc_hs.sv
// rtl/memacc_hs.sv - memory-access stage with req/ack data memory; optional MEMACC_MISALIGN_TRAP_EN
module memacc_hs
  import memacc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int RES_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    next_pc_in,
  input  logic               rd_write_enable_in,
  input  logic [RADDR_W-1:0] rd_write_addr_in,
  input  logic [RES_W-1:0]   res_src_in,
  input  logic [XLEN-1:0]    exec_data_in,
  input  logic               mem_read_in,
  input  logic               mem_write_enable,
  input  logic [XLEN-1:0]    mem_write_data,
  input  logic [2:0]         mem_width,
  memacc_hs_if.master        dmem,
  output logic               out_valid,
  output logic [XLEN-1:0]    exec_data_out,
  output logic [XLEN-1:0]    mem_data_out,
  output logic [XLEN-1:0]    next_pc_out,
  output logic               rd_write_enable_out,
  output logic [RADDR_W-1:0] rd_write_addr_out,
`ifdef MEMACC_MISALIGN_TRAP_EN
  output logic               misalign_trap,
  output logic [XLEN-1:0]    misalign_addr,
`endif
  output logic [RES_W-1:0]   res_src_out
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  state_e state_q, state_d;

  logic [OFF_W-1:0] in_off;
  logic             is_mem;
  logic             hold_load;
  logic             wb_load;
  logic             wb_from_mem;
  logic             trap_d;

  // Holding registers for the access in flight
  logic [XLEN-1:0]    hold_addr_q;
  logic               hold_we_q;
  logic [BE_W-1:0]    hold_be_q;
  logic [XLEN-1:0]    hold_wdata_q;
  logic [OFF_W-1:0]   hold_off_q;
  logic [2:0]         hold_width_q;
  logic [XLEN-1:0]    hold_exec_q;
  logic [XLEN-1:0]    hold_pc_q;
  logic               hold_rd_we_q;
  logic [RADDR_W-1:0] hold_rd_addr_q;
  logic [RES_W-1:0]   hold_res_q;

  // Writeback registers
  logic               out_valid_q;
  logic [XLEN-1:0]    exec_data_q;
  logic [XLEN-1:0]    mem_data_q;
  logic [XLEN-1:0]    next_pc_q;
  logic               rd_we_q;
  logic [RADDR_W-1:0] rd_addr_q;
  logic [RES_W-1:0]   res_src_q;
  logic               trap_q;
  logic [XLEN-1:0]    trap_addr_q;

  logic [XLEN-1:0]    load_res;

  assign in_off = exec_data_in[OFF_W-1:0];
  assign is_mem = mem_read_in | mem_write_enable;

  // State register; reset abandons any request in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and load strobes for the holding/writeback registers
  always_comb begin
    state_d     = state_q;
    hold_load   = 1'b0;
    wb_load     = 1'b0;
    wb_from_mem = 1'b0;
    trap_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_mem) begin
`ifdef MEMACC_MISALIGN_TRAP_EN
            if (is_misaligned(mem_width, 3'(in_off))) begin
              wb_load = 1'b1;
              trap_d  = 1'b1;
            end else begin
              hold_load = 1'b1;
              state_d   = S_ACCESS;
            end
`else
            hold_load = 1'b1;
            state_d   = S_ACCESS;
`endif
          end else begin
            wb_load = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (dmem.dmem_ack) begin
          wb_from_mem = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the memory op so the bus stays stable for the whole wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_addr_q    <= '0;
      hold_we_q      <= 1'b0;
      hold_be_q      <= '0;
      hold_wdata_q   <= '0;
      hold_off_q     <= '0;
      hold_width_q   <= '0;
      hold_exec_q    <= '0;
      hold_pc_q      <= '0;
      hold_rd_we_q   <= 1'b0;
      hold_rd_addr_q <= '0;
      hold_res_q     <= '0;
    end else if (hold_load) begin
      hold_addr_q    <= {exec_data_in[XLEN-1:OFF_W], {OFF_W{1'b0}}};
      hold_we_q      <= mem_write_enable;
      hold_be_q      <= BE_W'(be_gen(mem_width, 3'(in_off)));
      hold_wdata_q   <= mem_write_data << {in_off, 3'b000};
      hold_off_q     <= in_off;
      hold_width_q   <= mem_width;
      hold_exec_q    <= exec_data_in;
      hold_pc_q      <= next_pc_in;
      hold_rd_we_q   <= rd_write_enable_in;
      hold_rd_addr_q <= rd_write_addr_in;
      hold_res_q     <= res_src_in;
    end
  end

  load_aligner #(.XLEN(XLEN)) u_load_aligner (
    .rdata  (dmem.dmem_rdata),
    .offset (hold_off_q),
    .width  (hold_width_q),
    .result (load_res)
  );

  // Writeback registers: pulse out_valid, hold data across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      exec_data_q <= '0;
      mem_data_q  <= '0;
      next_pc_q   <= '0;
      rd_we_q     <= 1'b0;
      rd_addr_q   <= '0;
      res_src_q   <= '0;
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      out_valid_q <= wb_load | wb_from_mem;
      trap_q      <= trap_d;
      if (trap_d) trap_addr_q <= exec_data_in;
      if (wb_load) begin
        exec_data_q <= exec_data_in;
        mem_data_q  <= '0;
        next_pc_q   <= next_pc_in;
        rd_we_q     <= rd_write_enable_in & ~trap_d;
        rd_addr_q   <= rd_write_addr_in;
        res_src_q   <= res_src_in;
      end else if (wb_from_mem) begin
        exec_data_q <= hold_exec_q;
        mem_data_q  <= hold_we_q ? '0 : load_res;
        next_pc_q   <= hold_pc_q;
        rd_we_q     <= hold_rd_we_q;
        rd_addr_q   <= hold_rd_addr_q;
        res_src_q   <= hold_res_q;
      end
    end
  end

  assign in_ready            = (state_q == S_IDLE);
  assign dmem.dmem_req       = (state_q == S_ACCESS);
  assign dmem.dmem_we        = hold_we_q;
  assign dmem.dmem_addr      = hold_addr_q;
  assign dmem.dmem_be        = hold_be_q;
  assign dmem.dmem_wdata     = hold_wdata_q;

  assign out_valid           = out_valid_q;
  assign exec_data_out       = exec_data_q;
  assign mem_data_out        = mem_data_q;
  assign next_pc_out         = next_pc_q;
  assign rd_write_enable_out = rd_we_q & out_valid_q;
  assign rd_write_addr_out   = rd_addr_q;
  assign res_src_out         = res_src_q;

`ifdef MEMACC_MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
  assign misalign_addr = trap_addr_q;
`else
  logic unused_trap;
  assign unused_trap = trap_q | (|trap_addr_q);
`endif

endmodule

// File: tb/tb_memacc_hs.sv
// tb/tb_memacc_hs.sv - self-checking bench for memacc_hs (table vectors, sequences, random ops)
module tb_memacc_hs;
  import memacc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] next_pc_in = '0;
  logic        rd_write_enable_in = 1'b0;
  logic [4:0]  rd_write_addr_in = '0;
  logic [1:0]  res_src_in = '0;
  logic [31:0] exec_data_in = '0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_enable = 1'b0;
  logic [31:0] mem_write_data = '0;
  logic [2:0]  mem_width = '0;
  logic        out_valid;
  logic [31:0] exec_data_out, mem_data_out, next_pc_out;
  logic        rd_write_enable_out;
  logic [4:0]  rd_write_addr_out;
  logic [1:0]  res_src_out;
`ifdef MEMACC_MISALIGN_TRAP_EN
  logic        misalign_trap;
  logic [31:0] misalign_addr;
`endif

  memacc_hs_if #(.XLEN(32)) dmem ();

  memacc_hs #(.XLEN(32), .RADDR_W(5), .RES_W(2)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .next_pc_in          (next_pc_in),
    .rd_write_enable_in  (rd_write_enable_in),
    .rd_write_addr_in    (rd_write_addr_in),
    .res_src_in          (res_src_in),
    .exec_data_in        (exec_data_in),
    .mem_read_in         (mem_read_in),
    .mem_write_enable    (mem_write_enable),
    .mem_write_data      (mem_write_data),
    .mem_width           (mem_width),
    .dmem                (dmem),
    .out_valid           (out_valid),
    .exec_data_out       (exec_data_out),
    .mem_data_out        (mem_data_out),
    .next_pc_out         (next_pc_out),
    .rd_write_enable_out (rd_write_enable_out),
    .rd_write_addr_out   (rd_write_addr_out),
`ifdef MEMACC_MISALIGN_TRAP_EN
    .misalign_trap       (misalign_trap),
    .misalign_addr       (misalign_addr),
`endif
    .res_src_out         (res_src_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  w;
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] md;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: load value from the spec's rules using plain arithmetic
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int off, input logic [2:0] w);
    longint v;
    int bits;
    bits = 8 * (1 << (w % 4));
    v = longint'(rdata) >> (8 * off);
    v = v % (longint'(1) << bits);
    if (w < 4 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return 32'(v);
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] w, input int off);
    int size;
    size = 1 << (w % 4);
    return 4'(((1 << size) - 1) << off);
  endfunction

  // Memory op starting at a negedge in IDLE; ends at the negedge where out_valid is high
  task automatic mem_op(input logic ld, input logic st, input logic [2:0] w, input logic [31:0] addr,
                        input logic [31:0] data, input int waits, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_md, input logic [4:0] rd);
    chk("mem_in_ready_idle", in_ready, 1);
    in_valid = 1; mem_read_in = ld; mem_write_enable = st; mem_width = w;
    exec_data_in = addr; mem_write_data = st ? data : 32'h0;
    rd_write_enable_in = ld; rd_write_addr_in = rd; res_src_in = ld ? 2'd1 : 2'd0;
    next_pc_in = addr + 32'd4;
    @(negedge clk);
    in_valid = 0; mem_read_in = 0; mem_write_enable = 0;
    for (int k = 0; k <= waits; k++) begin
      chk("acc_req", dmem.dmem_req, 1);
      chk("acc_in_ready", in_ready, 0);
      chk("acc_bubble_valid", out_valid, 0);
      chk("acc_bubble_rdwe", rd_write_enable_out, 0);
      chk("acc_we", dmem.dmem_we, st);
      chk("acc_addr", dmem.dmem_addr, {addr[31:2], 2'b00});
      chk("acc_be", dmem.dmem_be, exp_be);
      if (st) chk("acc_wdata", dmem.dmem_wdata, exp_wd);
      dmem.dmem_rdata = (k == waits && ld) ? data : $urandom;
      dmem.dmem_ack = (k == waits);
      @(negedge clk);
      dmem.dmem_ack = 0;
    end
    chk("wb_valid", out_valid, 1);
    chk("wb_req_low", dmem.dmem_req, 0);
    chk("wb_in_ready", in_ready, 1);
    if (ld) chk("wb_mem_data", mem_data_out, exp_md);
    chk("wb_rdwe", rd_write_enable_out, ld);
    chk("wb_rdaddr", rd_write_addr_out, rd);
    chk("wb_exec", exec_data_out, addr);
    chk("wb_pc", next_pc_out, addr + 32'd4);
    chk("wb_res", res_src_out, ld ? 2'd1 : 2'd0);
  endtask

  // Non-memory op: out_valid next cycle, then a bubble that holds the data
  task automatic alu_op(input logic [31:0] val, input logic [4:0] rd, input logic we);
    chk("alu_in_ready", in_ready, 1);
    in_valid = 1; mem_read_in = 0; mem_write_enable = 0;
    exec_data_in = val; rd_write_enable_in = we; rd_write_addr_in = rd;
    res_src_in = 2'd2; next_pc_in = val ^ 32'h1000;
    @(negedge clk);
    in_valid = 0;
    chk("alu_valid", out_valid, 1);
    chk("alu_exec", exec_data_out, val);
    chk("alu_rdaddr", rd_write_addr_out, rd);
    chk("alu_rdwe", rd_write_enable_out, we);
    chk("alu_memdata_zero", mem_data_out, 0);
    chk("alu_res", res_src_out, 2'd2);
    chk("alu_pc", next_pc_out, val ^ 32'h1000);
    @(negedge clk);
    chk("alu_bubble_valid", out_valid, 0);
    chk("alu_bubble_rdwe", rd_write_enable_out, 0);
    chk("alu_bubble_hold", exec_data_out, val);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    dmem.dmem_ack = 0;
    dmem.dmem_rdata = '0;

    tbl[0] = '{1'b1, 1'b0, F3_B,  32'h103, 32'h80FFFFFF, 3, 4'b1000, 32'h0,        32'hFFFFFF80};
    tbl[1] = '{1'b1, 1'b0, F3_BU, 32'h103, 32'h80FFFFFF, 3, 4'b1000, 32'h0,        32'h00000080};
    tbl[2] = '{1'b0, 1'b1, F3_H,  32'h202, 32'h0000ABCD, 0, 4'b1100, 32'hABCD0000, 32'h0};
    tbl[3] = '{1'b1, 1'b0, F3_W,  32'h010, 32'hDEADBEEF, 1, 4'b1111, 32'h0,        32'hDEADBEEF};
    tbl[4] = '{1'b1, 1'b0, F3_H,  32'h102, 32'h80011234, 2, 4'b1100, 32'h0,        32'hFFFF8001};
    tbl[5] = '{1'b1, 1'b0, F3_HU, 32'h102, 32'h80011234, 0, 4'b1100, 32'h0,        32'h00008001};
    tbl[6] = '{1'b0, 1'b1, F3_B,  32'h301, 32'h0000005A, 1, 4'b0010, 32'h00005A00, 32'h0};
    tbl[7] = '{1'b0, 1'b1, F3_W,  32'h044, 32'hCAFEF00D, 0, 4'b1111, 32'hCAFEF00D, 32'h0};

    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req", dmem.dmem_req, 0);
    chk("rst_rdwe", rd_write_enable_out, 0);
    chk("rst_exec", exec_data_out, 0);
    chk("rst_memdata", mem_data_out, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // ALU pass-through
    alu_op(32'h1234, 5'd5, 1'b1);

    // Table vectors
    for (int i = 0; i < 8; i++)
      mem_op(tbl[i].ld, tbl[i].st, tbl[i].w, tbl[i].addr, tbl[i].data, tbl[i].waits,
             tbl[i].be, tbl[i].wd, tbl[i].md, 5'(i + 1));
    @(negedge clk);

    // Reset held mid-access: request drops at once, late ack ignored
    in_valid = 1; mem_read_in = 1; mem_width = F3_W; exec_data_in = 32'h40;
    rd_write_enable_in = 1; rd_write_addr_in = 5'd3;
    @(negedge clk);
    in_valid = 0; mem_read_in = 0;
    chk("rstmid_req_before", dmem.dmem_req, 1);
    #2 rst_n = 0;
    #1 chk("rstmid_req_async", dmem.dmem_req, 0);
    @(negedge clk);
    rst_n = 1;
    chk("rstmid_in_ready", in_ready, 1);
    chk("rstmid_out_valid", out_valid, 0);
    dmem.dmem_ack = 1; dmem.dmem_rdata = 32'h55AA55AA;
    @(negedge clk);
    dmem.dmem_ack = 0;
    chk("late_ack_valid", out_valid, 0);
    chk("late_ack_req", dmem.dmem_req, 0);
    chk("late_ack_ready", in_ready, 1);
    chk("late_ack_rdwe", rd_write_enable_out, 0);

    // Back-to-back: ALU op waiting behind a load is accepted as the load completes
    in_valid = 1; mem_read_in = 1; mem_width = F3_W; exec_data_in = 32'h80;
    rd_write_enable_in = 1; rd_write_addr_in = 5'd7; res_src_in = 2'd1;
    @(negedge clk);
    mem_read_in = 0; exec_data_in = 32'h5555; rd_write_addr_in = 5'd9; res_src_in = 2'd0;
    chk("b2b_stall", in_ready, 0);
    dmem.dmem_ack = 1; dmem.dmem_rdata = 32'h11223344;
    @(negedge clk);
    dmem.dmem_ack = 0;
    chk("b2b_load_valid", out_valid, 1);
    chk("b2b_load_data", mem_data_out, 32'h11223344);
    chk("b2b_load_rd", rd_write_addr_out, 7);
    chk("b2b_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    chk("b2b_alu_valid", out_valid, 1);
    chk("b2b_alu_exec", exec_data_out, 32'h5555);
    chk("b2b_alu_rd", rd_write_addr_out, 9);
    chk("b2b_alu_memdata", mem_data_out, 0);
    @(negedge clk);
    chk("b2b_bubble", out_valid, 0);

    // Ack while idle is ignored
    dmem.dmem_ack = 1;
    @(negedge clk);
    dmem.dmem_ack = 0;
    chk("idle_ack_valid", out_valid, 0);
    chk("idle_ack_ready", in_ready, 1);

`ifdef MEMACC_MISALIGN_TRAP_EN
    // Misaligned word load traps without touching memory
    in_valid = 1; mem_read_in = 1; mem_width = F3_W; exec_data_in = 32'h3;
    rd_write_enable_in = 1; rd_write_addr_in = 5'd4;
    @(negedge clk);
    in_valid = 0; mem_read_in = 0;
    chk("trap_no_req", dmem.dmem_req, 0);
    chk("trap_valid", out_valid, 1);
    chk("trap_flag", misalign_trap, 1);
    chk("trap_addr", misalign_addr, 32'h3);
    chk("trap_rdwe", rd_write_enable_out, 0);
    chk("trap_ready", in_ready, 1);
    @(negedge clk);
    chk("trap_pulse", misalign_trap, 0);
`endif

    // Random aligned ops against the reference model
    for (int n = 0; n < 40; n++) begin
      int kind, off, size, waits;
      logic [2:0] w;
      logic [31:0] base, data, addr;
      kind = $urandom_range(0, 2);
      base = $urandom;
      data = $urandom;
      if (kind == 0) begin
        alu_op(data, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end else begin
        case ($urandom_range(0, 4))
          0: w = F3_B;
          1: w = F3_H;
          2: w = F3_W;
          3: w = F3_BU;
          default: w = F3_HU;
        endcase
        if (kind == 2 && w[2]) w = {1'b0, w[1:0]};
        size = 1 << (w % 4);
        off = ($urandom_range(0, 3) / size) * size;
        addr = {base[31:2], 2'(off)};
        waits = $urandom_range(0, 3);
        mem_op(kind == 1, kind == 2, w, addr, data, waits, ref_be(w, off),
               32'(longint'(data) << (8 * off)), ref_load(data, off, w), 5'($urandom_range(1, 31)));
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
